// File: rtl/tc_pcie_rxwidth_ctrl.sv
// Purpose : owns the rx width converter's rxwidth select and sequences width changes on 80-bit word boundaries.
// Latency : same-width ack 1 cycle; a real switch acks (t-b)+2+SETTLE_CYCLES cycles after the request.
// Backpres: no flow control; requests arriving while busy are discarded and flagged on req_drop_o.
//
// Ports:
//   rxclk_i        receive clock, rising edge
//   reset_i        synchronous active-high reset
//   width_req_i    width change request strobe (acted on only in RUN)
//   width_sel_i    requested width code (0=10b, 1=20b, 2=40b, 3=80b)
//   rxwidth_o      width code driven to the converter
//   conv_hold_o    converter output invalid (SWITCH/SETTLE)
//   beat_cnt_o     beat index inside the current 80-bit word
//   word_valid_o   current beat completes an 80-bit word
//   width_ack_o    one-cycle pulse: requested width is in effect
//   busy_o         a width change is in progress
//   req_drop_o     one-cycle pulse: a request was discarded while busy
//   switch_cnt_o   completed switch count (live only with TC_PCIE_RXWIDTH_STATS_EN)
//
// Build option: define TC_PCIE_RXWIDTH_STATS_EN to enable the saturating switch counter;
// otherwise switch_cnt_o is tied to zero.

module tc_pcie_rxwidth_ctrl #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [1:0] RESET_WIDTH   = 2'd3
) (
  input  logic        rxclk_i,
  input  logic        reset_i,
  input  logic        width_req_i,
  input  logic [1:0]  width_sel_i,
  output logic [1:0]  rxwidth_o,
  output logic        conv_hold_o,
  output logic [2:0]  beat_cnt_o,
  output logic        word_valid_o,
  output logic        width_ack_o,
  output logic        busy_o,
  output logic        req_drop_o,
  output logic [15:0] switch_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Settle counter counts SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] rxwidth_q;
  logic [1:0] pend_q;
  logic [2:0] beat_q;
  logic [3:0] settle_q;
  logic       hold_q;
  logic       busy_q;
  logic       ack_q;
  logic       drop_q;

  logic [2:0] term_beat;
  logic       word_end;
  logic [2:0] beat_next;
  logic       run_switch_req;
  logic       sw_go;

  // Number of converter beats per 80-bit word, minus one.
  always_comb begin
    term_beat = 3'd0;
    case (rxwidth_q)
      2'd0:    term_beat = 3'd7;
      2'd1:    term_beat = 3'd3;
      2'd2:    term_beat = 3'd1;
      default: term_beat = 3'd0;
    endcase
  end

  assign word_end  = (beat_q == term_beat);
  assign beat_next = word_end ? 3'd0 : beat_q + 3'd1;

  // A width change request that actually changes width.
  assign run_switch_req = (state_q == ST_RUN) && width_req_i && (width_sel_i != rxwidth_q);

  // SWITCH is entered only on the last beat of a word, so the converter never
  // changes width mid-word.
  assign sw_go = word_end && (run_switch_req || (state_q == ST_DRAIN));

  always_ff @(posedge rxclk_i) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      rxwidth_q <= RESET_WIDTH;
      pend_q    <= RESET_WIDTH;
      beat_q    <= 3'd0;
      settle_q  <= 4'd0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          beat_q <= beat_next;
          if (width_req_i) begin
            if (width_sel_i == rxwidth_q) begin
              // Already at the requested width: acknowledge without disturbing the converter.
              ack_q <= 1'b1;
            end else begin
              pend_q <= width_sel_i;
              busy_q <= 1'b1;
              if (sw_go) begin
                // Request lands on the word's last beat: switch immediately,
                // taking the width straight from the request.
                state_q   <= ST_SWITCH;
                rxwidth_q <= width_sel_i;
                hold_q    <= 1'b1;
              end else begin
                state_q <= ST_DRAIN;
              end
            end
          end
        end

        ST_DRAIN: begin
          beat_q <= beat_next;
          if (width_req_i) begin
            drop_q <= 1'b1;
          end
          if (sw_go) begin
            state_q   <= ST_SWITCH;
            rxwidth_q <= pend_q;
            hold_q    <= 1'b1;
          end
        end

        ST_SWITCH: begin
          beat_q   <= 3'd0;
          settle_q <= SETTLE_LOAD;
          state_q  <= ST_SETTLE;
          if (width_req_i) begin
            drop_q <= 1'b1;
          end
        end

        ST_SETTLE: begin
          beat_q <= 3'd0;
          if (width_req_i) begin
            drop_q <= 1'b1;
          end
          if (settle_q == 4'd0) begin
            state_q <= ST_RUN;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end

        default: begin
          state_q <= ST_RUN;
          hold_q  <= 1'b0;
          busy_q  <= 1'b0;
          beat_q  <= 3'd0;
        end
      endcase
    end
  end

`ifdef TC_PCIE_RXWIDTH_STATS_EN
  logic [15:0] switch_cnt_q;

  // Counts entries into SWITCH; value is visible from the SWITCH cycle onward.
  always_ff @(posedge rxclk_i) begin
    if (reset_i) begin
      switch_cnt_q <= 16'd0;
    end else if (sw_go && (switch_cnt_q != 16'hFFFF)) begin
      switch_cnt_q <= switch_cnt_q + 16'd1;
    end
  end

  assign switch_cnt_o = switch_cnt_q;
`else
  assign switch_cnt_o = 16'd0;
`endif

  assign rxwidth_o    = rxwidth_q;
  assign conv_hold_o  = hold_q;
  assign beat_cnt_o   = beat_q;
  assign word_valid_o = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && word_end;
  assign width_ack_o  = ack_q;
  assign busy_o       = busy_q;
  assign req_drop_o   = drop_q;

endmodule
